// File: rtl/sm83_bus_responder.sv
// rtl/sm83_bus_responder.sv - sm83 bus target: HRAM, IF/IE, OAM DMA engine and address routing
module sm83_bus_responder #(
    parameter int          DMA_LEN   = 160,
    parameter logic [15:0] HRAM_BASE = 16'hFF80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_write,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_write,
    input  logic [7:0]  oam_rdata,
    input  logic [4:0]  irq_req,
    input  logic [4:0]  irq_clr,
    output logic        int_pending,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_ACTIVE
    } dma_state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    // Entry 127 would alias IE at FFFF and is never written or read.
    logic [7:0]  hram [0:127];
    logic [7:0]  ie_reg;
    logic [4:0]  if_reg;
    logic [4:0]  if_next;
    logic [7:0]  dma_reg;
    logic [7:0]  src_fold;
    logic [7:0]  idx;
    logic [7:0]  idx_next;
    dma_state_t  state;
    dma_state_t  state_next;

    logic is_ie;
    logic is_if;
    logic is_dma;
    logic is_hram;
    logic is_oam;
    logic is_unused;
    logic is_ext;
    logic cpu_wr;
    logic dma_wr;
    logic active;

    assign is_ie     = (cpu_addr == 16'hFFFF);
    assign is_if     = (cpu_addr == 16'hFF0F);
    assign is_dma    = (cpu_addr == 16'hFF46);
    assign is_hram   = (cpu_addr >= HRAM_BASE) && !is_ie;
    assign is_oam    = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign is_unused = (cpu_addr >= 16'hFEA0) && (cpu_addr <= 16'hFEFF);
    assign is_ext    = !(is_ie | is_if | is_dma | is_hram | is_oam | is_unused);

    // A CPU write only counts on an M-cycle strobe and never while held in reset.
    assign cpu_wr = ce & cpu_write & ~rst;
    assign dma_wr = cpu_wr & is_dma;
    assign active = (state == ST_ACTIVE);

    // Sources E0-FF fold down onto the C0-DF work RAM they echo.
    assign src_fold = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

    // Interrupt set wins over acknowledge, which wins over the CPU write.
    assign if_next = (((cpu_wr & is_if) ? cpu_wdata[4:0] : if_reg) & ~irq_clr) | irq_req;

    assign int_pending = |(ie_reg[4:0] & if_reg);
    assign dma_active  = active;

    // HRAM contents survive reset; only CPU writes change them.
    always_ff @(posedge clk) begin
        if (cpu_wr && is_hram) begin
            hram[cpu_addr[6:0]] <= cpu_wdata;
        end
    end

    // IF tracks every clock; IE and the DMA source register move only on ce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_reg  <= 8'h00;
            if_reg  <= 5'h00;
            dma_reg <= 8'h00;
        end else begin
            if_reg <= if_next;
            if (cpu_wr && is_ie) begin
                ie_reg <= cpu_wdata;
            end
            if (dma_wr) begin
                dma_reg <= cpu_wdata;
            end
        end
    end

    // DMA state and byte index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= 8'h00;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // DMA sequencing: a FF46 write always (re)starts via one idle START cycle.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (dma_wr) begin
                        state_next = ST_START;
                    end
                end
                ST_START: begin
                    idx_next   = 8'h00;
                    state_next = dma_wr ? ST_START : ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (dma_wr) begin
                        state_next = ST_START;
                        idx_next   = 8'h00;
                    end else begin
                        idx_next = idx + 8'd1;
                        if (idx == LAST_IDX) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = 8'h00;
                end
            endcase
        end
    end

    // Port routing and CPU read mux; DMA owns the external and OAM ports while active.
    always_comb begin
        ext_addr  = cpu_addr;
        ext_wdata = cpu_wdata;
        ext_write = 1'b0;
        oam_addr  = cpu_addr[7:0];
        oam_wdata = cpu_wdata;
        oam_write = 1'b0;
        cpu_rdata = 8'hFF;

        if (active) begin
            ext_addr  = {src_fold, idx};
            oam_addr  = idx;
            oam_wdata = ext_rdata;
            oam_write = ce & ~rst;
        end else begin
            ext_write = cpu_wr & is_ext;
            oam_write = cpu_wr & is_oam;
        end

        if (is_ie) begin
            cpu_rdata = ie_reg;
        end else if (is_hram) begin
            cpu_rdata = hram[cpu_addr[6:0]];
        end else if (is_if) begin
            cpu_rdata = {3'b111, if_reg};
        end else if (is_dma) begin
            cpu_rdata = dma_reg;
        end else if (active) begin
            cpu_rdata = 8'hFF;
        end else if (is_oam) begin
            cpu_rdata = oam_rdata;
        end else if (is_unused) begin
            cpu_rdata = 8'h00;
        end else begin
            cpu_rdata = ext_rdata;
        end
    end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// tb/tb_sm83_bus_responder.sv - self-checking bench for sm83_bus_responder
module tb_sm83_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_rdata;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_write;
    logic [7:0]  ext_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write;
    logic [7:0]  oam_rdata = 8'h3C;
    logic [4:0]  irq_req = 5'h00;
    logic [4:0]  irq_clr = 5'h00;
    logic        int_pending;
    logic        dma_active;

    int n_checks = 0;
    int n_err = 0;

    sm83_bus_responder dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_write(ext_write), .ext_rdata(ext_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_write(oam_write), .oam_rdata(oam_rdata),
        .irq_req(irq_req), .irq_clr(irq_clr), .int_pending(int_pending), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // External memory returns the low byte of whatever address it is given.
    always_comb ext_rdata = ext_addr[7:0];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers plus "ce edges since the last FF46 write".
    logic [7:0] m_hram [0:127];
    bit         m_valid [0:127];
    logic [7:0] m_ie;
    logic [7:0] m_dma;
    logic [4:0] m_if;
    int         m_k;

    initial begin
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        m_k = -1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ie  = 8'h00;
            m_if  = 5'h00;
            m_dma = 8'h00;
            m_k   = -1;
        end else begin
            if (ce && cpu_write && cpu_addr == 16'hFF0F)
                m_if = cpu_wdata[4:0];
            m_if = (m_if & ~irq_clr) | irq_req;
            if (ce) begin
                if (cpu_write && cpu_addr == 16'hFFFF) m_ie = cpu_wdata;
                if (cpu_write && cpu_addr >= 16'hFF80 && cpu_addr != 16'hFFFF) begin
                    m_hram[cpu_addr[6:0]]  = cpu_wdata;
                    m_valid[cpu_addr[6:0]] = 1'b1;
                end
                if (cpu_write && cpu_addr == 16'hFF46) begin
                    m_dma = cpu_wdata;
                    m_k   = 0;
                end else if (m_k >= 0 && m_k <= 160) begin
                    m_k = m_k + 1;
                end
            end
        end
    end

    bit         e_act, e_ew, e_ow, e_rd_ok, r_oam, r_unu, r_own, r_ext;
    int         e_t;
    logic [7:0] e_fold, e_rd;

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        e_act  = (m_k >= 1) && (m_k <= 160);
        e_t    = m_k - 1;
        e_fold = (m_dma >= 8'hE0) ? m_dma - 8'h20 : m_dma;
        r_oam  = cpu_addr >= 16'hFE00 && cpu_addr <= 16'hFE9F;
        r_unu  = cpu_addr >= 16'hFEA0 && cpu_addr <= 16'hFEFF;
        r_own  = cpu_addr == 16'hFF0F || cpu_addr == 16'hFF46 || cpu_addr >= 16'hFF80;
        r_ext  = !r_oam && !r_unu && !r_own;
        e_ew   = !rst && ce && cpu_write && !e_act && r_ext;
        e_ow   = !rst && ce && (e_act || (cpu_write && r_oam));
        chk("ext_write", 16'(ext_write), 16'(e_ew));
        chk("oam_write", 16'(oam_write), 16'(e_ow));
        chk("dma_active", 16'(dma_active), 16'(e_act));
        chk("int_pending", 16'(int_pending), 16'(|(m_ie[4:0] & m_if)));
        if (e_act) begin
            chk("dma_ext_addr", ext_addr, {e_fold, e_t[7:0]});
            chk("dma_oam_addr", 16'(oam_addr), 16'(e_t[7:0]));
            chk("dma_oam_wdata", 16'(oam_wdata), 16'(e_t[7:0]));
        end else if (e_ow) begin
            chk("cpu_oam_addr", 16'(oam_addr), 16'(cpu_addr[7:0]));
            chk("cpu_oam_wdata", 16'(oam_wdata), 16'(cpu_wdata));
        end
        if (e_ew) begin
            chk("cpu_ext_addr", ext_addr, cpu_addr);
            chk("cpu_ext_wdata", 16'(ext_wdata), 16'(cpu_wdata));
        end
        e_rd_ok = 1'b1;
        if (cpu_addr == 16'hFFFF) e_rd = m_ie;
        else if (cpu_addr >= 16'hFF80) begin
            e_rd    = m_hram[cpu_addr[6:0]];
            e_rd_ok = m_valid[cpu_addr[6:0]];
        end
        else if (cpu_addr == 16'hFF0F) e_rd = {3'b111, m_if};
        else if (cpu_addr == 16'hFF46) e_rd = m_dma;
        else if (e_act) e_rd = 8'hFF;
        else if (r_oam) e_rd = oam_rdata;
        else if (r_unu) e_rd = 8'h00;
        else e_rd = cpu_addr[7:0];
        if (e_rd_ok) chk("cpu_rdata", 16'(cpu_rdata), 16'(e_rd));
    end

    task automatic set(input logic [15:0] a, input logic w, input logic [7:0] d);
        cpu_addr  = a;
        cpu_write = w;
        cpu_wdata = d;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
    endtask

    int  cnt;
    int  act_cnt;
    bit  found;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        set(16'hFF46, 0, 8'h00); chk("rst_ff46", 16'(cpu_rdata), 16'h00); tick();
        set(16'hFFFF, 0, 8'h00); chk("rst_ie", 16'(cpu_rdata), 16'h00); tick();

        set(16'hFF80, 1, 8'h5A); tick();
        set(16'hFFFE, 1, 8'hA5); tick();
        set(16'hFF80, 0, 8'h00); chk("hram_ff80", 16'(cpu_rdata), 16'h5A); tick();
        set(16'hFFFE, 0, 8'h00); chk("hram_fffe", 16'(cpu_rdata), 16'hA5); tick();

        set(16'hFF81, 1, 8'h11); tick();
        ce = 1'b0; set(16'hFF81, 1, 8'h33); tick(); ce = 1'b1;
        set(16'hFF81, 0, 8'h00); chk("ce0_write_dropped", 16'(cpu_rdata), 16'h11); tick();

        set(16'hFFFF, 1, 8'h1F); tick();
        set(16'hFF0F, 1, 8'h05); irq_req = 5'b10000; tick(); irq_req = 5'h00;
        set(16'hFF0F, 0, 8'h00); chk("if_set", 16'(cpu_rdata), 16'hF5);
        chk("int_pending_on", 16'(int_pending), 16'h1);
        irq_clr = 5'b00101; tick(); irq_clr = 5'h00;
        set(16'hFF0F, 0, 8'h00); chk("if_clr", 16'(cpu_rdata), 16'hF0); tick();
        ce = 1'b0; irq_req = 5'b00010; tick(); irq_req = 5'h00; ce = 1'b1;
        set(16'hFF0F, 0, 8'h00); chk("if_set_ce0", 16'(cpu_rdata), 16'hF2); tick();

        set(16'h8000, 1, 8'h9C); chk("ext_wr", 16'(ext_write), 16'h1);
        chk("ext_wr_addr", ext_addr, 16'h8000); tick();
        set(16'hC005, 0, 8'h00); chk("ext_rd", 16'(cpu_rdata), 16'h05); tick();
        set(16'hFE10, 0, 8'h00); chk("oam_rd", 16'(cpu_rdata), 16'h3C); tick();
        set(16'hFEA5, 1, 8'h77); chk("unused_rd", 16'(cpu_rdata), 16'h00);
        chk("unused_no_wr", 16'({ext_write, oam_write}), 16'h0); tick();

        set(16'hFF46, 1, 8'hC1); tick();
        set(16'hFF90, 0, 8'h00); chk("dma_start_gap", 16'(dma_active), 16'h0);
        cnt = 0; act_cnt = 0;
        for (int i = 0; i < 170; i++) begin
            set(16'hFF90, 0, 8'h00);
            if (dma_active) act_cnt++;
            if (oam_write) begin
                chk("seq_oam_addr", 16'(oam_addr), 16'(cnt));
                chk("seq_oam_data", 16'(oam_wdata), 16'(cnt));
                chk("seq_ext_addr", ext_addr, 16'hC100 + 16'(cnt));
                cnt++;
            end
            tick();
        end
        chk("dma_oam_count", 16'(cnt), 16'd160);
        chk("dma_active_span", 16'(act_cnt), 16'd160);

        set(16'hFF46, 1, 8'hF2); tick();
        set(16'hFF90, 0, 8'h00); chk("echo_start_no_wr", 16'(oam_write), 16'h0); tick();
        set(16'hFF90, 0, 8'h00); chk("echo_first_addr", ext_addr, 16'hD200);
        chk("echo_first_wr", 16'(oam_write), 16'h1); tick();
        set(16'hC000, 0, 8'h00); chk("blocked_rd", 16'(cpu_rdata), 16'hFF); tick();
        set(16'h8000, 1, 8'h44); chk("blocked_wr", 16'(ext_write), 16'h0); tick();
        set(16'hFF90, 1, 8'h77); tick();
        set(16'hFF90, 0, 8'h00); chk("hram_during_dma", 16'(cpu_rdata), 16'h77); tick();

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            set(16'hFF90, 0, 8'h00);
            if (dma_active && oam_addr == 8'd50) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("find_idx50", 16'(found), 16'h1);
        set(16'hFF46, 1, 8'hC1); tick();
        set(16'hFF90, 0, 8'h00); chk("restart_gap_act", 16'(dma_active), 16'h0);
        chk("restart_gap_wr", 16'(oam_write), 16'h0); tick();
        set(16'hFF90, 0, 8'h00); chk("restart_idx0", 16'(oam_addr), 16'h00);
        chk("restart_src", ext_addr, 16'hC100); tick();
        for (int i = 0; i < 19; i++) begin
            set(16'hFF90, 0, 8'h00);
            tick();
        end
        set(16'hFF90, 0, 8'h00); chk("idx20", 16'(oam_addr), 16'd20);
        rst = 1'b1; #1;
        chk("rst_mid_active", 16'(dma_active), 16'h0);
        chk("rst_mid_oam_wr", 16'(oam_write), 16'h0);
        set(16'hFFFF, 0, 8'h00); chk("rst_mid_ie", 16'(cpu_rdata), 16'h00);
        set(16'hFF0F, 0, 8'h00); chk("rst_mid_if", 16'(cpu_rdata[4:0]), 16'h00);
        tick(); tick();
        rst = 1'b0;
        set(16'hFF90, 0, 8'h00); chk("hram_survives_rst", 16'(cpu_rdata), 16'h77); tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
